uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
Parametrised UART transmitter; next generation of the fixed 8N1 rs232 transmitter.
- Configurable data width, parity mode and stop-bit count.
- Adds busy/done handshake so upstream logic can stream bytes without fixed delays.
- Sits between byte producers (loopback, FIFO drain, command engines) and the board TX pin.

Parameters:
UART_BPS, 9600, line baud rate in bit/s
CLK_FREQ, 50000000, system_clk frequency in Hz
DATA_W, 8, data bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame; legal values 1 or 2

Ports:
system_clk    input   1       system clock; all logic on rising edge
system_rst_n  input   1       asynchronous, active-low reset
pi_data       input   DATA_W  byte/word to transmit; sampled only on accept
pi_flag       input   1       request strobe; accepted only when po_busy = 0
po_busy       output  1       high from accept cycle+1 through end of last stop bit
po_done       output  1       one-cycle pulse on final cycle of the last stop bit
tx            output  1       serial line, idle high, LSB first

Interface (already decided): one clock, system_clk; reset system_rst_n is asynchronous and active-low.

Behaviour:
- Constants
  - BAUD_CNT_MAX = CLK_FREQ / UART_BPS, integer-truncated; 5208 at defaults.
  - P = 1 if PARITY != 0, else 0.
  - Frame length = BAUD_CNT_MAX * (1 + DATA_W + P + STOP_BITS) cycles.
- Reset (async assert, sync release)
  - tx = 1, po_busy = 0, po_done = 0.
  - State = IDLE; baud and bit counters = 0; data latch = 0.
- Accept
  - Condition: pi_flag = 1 in a cycle with state IDLE.
  - pi_data latched that cycle; parity bit computed from the latched value.
  - pi_flag while busy is ignored; no queueing, no error flag.
- Latency: tx falls (start bit) and po_busy rises on the cycle after accept.
- FSM states IDLE, START, DATA, PAR, STOP:
  - IDLE: tx = 1. On accept go to START.
  - START: tx = 0 for BAUD_CNT_MAX cycles, then DATA.
  - DATA: tx = data[bit_cnt], bit_cnt 0..DATA_W-1, each bit held BAUD_CNT_MAX cycles.
    - After the last bit: go to PAR if P = 1, else STOP.
  - PAR: tx = ^data for even, ~^data for odd; held one bit period, then STOP.
  - STOP: tx = 1 for STOP_BITS * BAUD_CNT_MAX cycles.
    - po_done = 1 on the final cycle; next cycle state = IDLE, po_busy = 0.
- Baud counter
  - Counts 0..BAUD_CNT_MAX-1 while not IDLE; bit_end asserted at BAUD_CNT_MAX-1.
  - Clears to 0 in IDLE and on every accept.
- Back-to-back
  - pi_flag asserted in the cycle po_busy drops is accepted.
  - Inter-frame gap is exactly one idle-high cycle.
  - pi_flag coincident with po_done is ignored.
- Outputs tx, po_busy, po_done are registered; no combinational path from inputs.
- Reset mid-frame: tx returns to 1 immediately (async); the frame is abandoned; no po_done.
- Width: counters sized with $clog2(BAUD_CNT_MAX) and $clog2(DATA_W+1).
- Illegal parameters (DATA_W outside 5..9, PARITY > 2, STOP_BITS not 1/2) fail elaboration via generate-time check.

Decomposition:
- Package uart_pkg:
  - Parity encodings PAR_NONE / PAR_ODD / PAR_EVEN.
  - FSM state encoding.
  - Function baud_cnt_max(clk_freq, bps).
- Sub-module uart_baud_gen:
  - Parameter CNT_MAX; inputs system_clk, system_rst_n, en.
  - Output bit_end pulse; counter clears when en = 0.
  - Reused by the future uart_rx_cfg.

Test Plan:
- Defaults, pi_data = 8'h55 one-cycle pulse after reset
  -> tx low 5208 cycles, then 1,0,1,0,1,0,1,0 LSB-first, then high 5208 cycles.
  -> po_done at cycle 52080 after the start edge; po_busy low the next cycle.
- PARITY = 2, pi_data = 8'h07 -> parity bit 1. PARITY = 1, same data -> parity bit 0. Frame = 11 bit periods.
- DATA_W = 5, STOP_BITS = 2, pi_data = 5'h1F -> 1 start + 5 data + 2 stop = 8 * 5208 cycles; stop held 10416 cycles.
- pi_flag with 8'hAA 100 cycles into an 8'h0F frame -> ignored; only the 8'h0F waveform appears; one po_done.
- pi_flag asserted the cycle po_busy falls, data 8'h01 then 8'h02 -> second start bit begins 1 cycle after first po_done.
- system_rst_n low for 3 cycles mid data bit 3 -> tx = 1 asynchronously, no po_done; next pi_flag sends a clean frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, TX FSM states, baud divisor helper.
package uart_pkg;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_ODD  = 1;
   localparam int unsigned PAR_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_PAR   = 3'd3,
      ST_STOP  = 3'd4
   } tx_state_e;

   // Clock cycles per bit period, integer-truncated.
   function automatic int unsigned baud_cnt_max(input int unsigned clk_freq,
                                                input int unsigned bps);
      return clk_freq / bps;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CNT_MAX-1 while enabled, held at zero otherwise.
module uart_baud_gen #(
   parameter int unsigned CNT_MAX = 5208
) (
   input  logic system_clk,
   input  logic system_rst_n,
   input  logic en,
   output logic bit_end,
   output logic bit_pre_end
);

   localparam int unsigned CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   logic [CNT_W-1:0] cnt_q;

   // Divisor must leave room for a distinct next-to-last count.
   generate
      if (CNT_MAX < 2) begin : g_bad_cnt_max
         $error("uart_baud_gen: CNT_MAX must be at least 2");
      end
   endgenerate

   // Free-running bit-period counter, cleared whenever disabled.
   always_ff @(posedge system_clk or negedge system_rst_n) begin
      if (!system_rst_n) begin
         cnt_q <= '0;
      end else if (!en || (cnt_q == CNT_W'(CNT_MAX - 1))) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // Last and next-to-last cycle of the current bit period.
   assign bit_end     = en && (cnt_q == CNT_W'(CNT_MAX - 1));
   assign bit_pre_end = en && (cnt_q == CNT_W'(CNT_MAX - 2));

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with busy/done handshake; LSB first, idle high.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int unsigned UART_BPS  = 9600,
   parameter int unsigned CLK_FREQ  = 50000000,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic              system_clk,
   input  logic              system_rst_n,
   input  logic [DATA_W-1:0] pi_data,
   input  logic              pi_flag,
   output logic              po_busy,
   output logic              po_done,
   output logic              tx
);

   localparam int unsigned BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
   localparam bit          HAS_PAR      = (PARITY != PAR_NONE);
   localparam int unsigned BIT_W        = $clog2(DATA_W + 1);
   localparam int unsigned PAD_W        = 1 << BIT_W;

   // Reject frame formats the FSM does not support.
   generate
      if ((DATA_W < 5) || (DATA_W > 9) || (PARITY > 2) ||
          ((STOP_BITS != 1) && (STOP_BITS != 2)) || (BAUD_CNT_MAX < 2)) begin : g_bad_param
         $error("uart_tx_cfg: illegal DATA_W, PARITY, STOP_BITS or baud divisor");
      end
   endgenerate

   tx_state_e         state_q;
   logic [DATA_W-1:0] data_q;
   logic [BIT_W-1:0]  bit_cnt_q;
   logic              tx_q;
   logic              busy_q;
   logic              done_q;

   logic              bit_end;
   logic              bit_pre_end;
   logic [PAD_W-1:0]  data_pad;
   logic [BIT_W-1:0]  nxt_idx;
   logic              par_bit;
   logic              last_data;
   logic              last_stop;

   uart_baud_gen #(
      .CNT_MAX (BAUD_CNT_MAX)
   ) u_baud_gen (
      .system_clk   (system_clk),
      .system_rst_n (system_rst_n),
      .en           (state_q != ST_IDLE),
      .bit_end      (bit_end),
      .bit_pre_end  (bit_pre_end)
   );

   // Data word padded to a power of two so the bit counter indexes it exactly.
   assign data_pad  = PAD_W'(data_q);
   assign nxt_idx   = bit_cnt_q + BIT_W'(1);
   assign par_bit   = (PARITY == PAR_EVEN) ? (^data_q) : (~^data_q);
   assign last_data = (bit_cnt_q == BIT_W'(DATA_W - 1));
   assign last_stop = (bit_cnt_q == BIT_W'(STOP_BITS - 1));

   // Frame sequencer; every line/handshake output is set one cycle ahead.
   always_ff @(posedge system_clk or negedge system_rst_n) begin
      if (!system_rst_n) begin
         state_q   <= ST_IDLE;
         data_q    <= '0;
         bit_cnt_q <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
               if (pi_flag) begin
                  data_q    <= pi_data;
                  bit_cnt_q <= '0;
                  tx_q      <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= ST_START;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  tx_q      <= data_q[0];
                  bit_cnt_q <= '0;
                  state_q   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  if (last_data) begin
                     bit_cnt_q <= '0;
                     if (HAS_PAR) begin
                        tx_q    <= par_bit;
                        state_q <= ST_PAR;
                     end else begin
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
                     end
                  end else begin
                     tx_q      <= data_pad[nxt_idx];
                     bit_cnt_q <= nxt_idx;
                  end
               end
            end
            ST_PAR: begin
               if (bit_end) begin
                  tx_q      <= 1'b1;
                  bit_cnt_q <= '0;
                  state_q   <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (bit_pre_end && last_stop) begin
                  done_q <= 1'b1;
               end
               if (bit_end) begin
                  if (last_stop) begin
                     bit_cnt_q <= '0;
                     busy_q    <= 1'b0;
                     tx_q      <= 1'b1;
                     state_q   <= ST_IDLE;
                  end else begin
                     bit_cnt_q <= nxt_idx;
                  end
               end
            end
            default: begin
               tx_q      <= 1'b1;
               busy_q    <= 1'b0;
               bit_cnt_q <= '0;
               state_q   <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx      = tx_q;
   assign po_busy = busy_q;
   assign po_done = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four frame formats driven in parallel against a frame-level model.
module tb_uart_tx_cfg;

   localparam int M = 5;  // 50 MHz / 10 Mbit/s
   localparam int DW  [4] = '{8, 8, 8, 5};
   localparam int PAR [4] = '{0, 2, 1, 0};
   localparam int STP [4] = '{1, 1, 1, 2};

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pi_flag = 1'b0;
   logic [7:0] pi_data = 8'h00;
   logic [3:0] tx_w, busy_w, done_w;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_tx_cfg #(.UART_BPS(10000000), .CLK_FREQ(50000000), .DATA_W(8), .PARITY(0), .STOP_BITS(1)) dut0 (
      .system_clk(clk), .system_rst_n(rst_n), .pi_data(pi_data), .pi_flag(pi_flag),
      .po_busy(busy_w[0]), .po_done(done_w[0]), .tx(tx_w[0]));
   uart_tx_cfg #(.UART_BPS(10000000), .CLK_FREQ(50000000), .DATA_W(8), .PARITY(2), .STOP_BITS(1)) dut1 (
      .system_clk(clk), .system_rst_n(rst_n), .pi_data(pi_data), .pi_flag(pi_flag),
      .po_busy(busy_w[1]), .po_done(done_w[1]), .tx(tx_w[1]));
   uart_tx_cfg #(.UART_BPS(10000000), .CLK_FREQ(50000000), .DATA_W(8), .PARITY(1), .STOP_BITS(1)) dut2 (
      .system_clk(clk), .system_rst_n(rst_n), .pi_data(pi_data), .pi_flag(pi_flag),
      .po_busy(busy_w[2]), .po_done(done_w[2]), .tx(tx_w[2]));
   uart_tx_cfg #(.UART_BPS(10000000), .CLK_FREQ(50000000), .DATA_W(5), .PARITY(0), .STOP_BITS(2)) dut3 (
      .system_clk(clk), .system_rst_n(rst_n), .pi_data(pi_data[4:0]), .pi_flag(pi_flag),
      .po_busy(busy_w[3]), .po_done(done_w[3]), .tx(tx_w[3]));

   // Frame as a bit list: start 0, data LSB first, optional parity, stop 1s.
   function automatic logic [15:0] build(input int k, input logic [7:0] d);
      logic [15:0] b;
      int idx;
      int ones;
      b = '0;
      idx = 1;
      ones = 0;
      for (int i = 0; i < DW[k]; i++) begin
         b[idx] = d[i];
         if (d[i]) ones++;
         idx++;
      end
      if (PAR[k] == 2) begin
         b[idx] = ((ones % 2) == 1);
         idx++;
      end else if (PAR[k] == 1) begin
         b[idx] = ((ones % 2) == 0);
         idx++;
      end
      for (int s = 0; s < STP[k]; s++) begin
         b[idx] = 1'b1;
         idx++;
      end
      return b;
   endfunction

   function automatic int nbits(input int k);
      return 1 + DW[k] + ((PAR[k] != 0) ? 1 : 0) + STP[k];
   endfunction

   // Model: a frame is a list of bits, each lasting M cycles, counted from the cycle after accept.
   bit          m_act  [4];
   int          m_t    [4];
   int          m_nb   [4];
   logic [15:0] m_bits [4];

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 4; k++) begin
         if (!rst_n) begin
            m_act[k] <= 1'b0;
            m_t[k]   <= 0;
         end else if (m_act[k]) begin
            m_t[k] <= m_t[k] + 1;
            if (m_t[k] + 1 == m_nb[k] * M) m_act[k] <= 1'b0;
         end else if (pi_flag) begin
            m_bits[k] <= build(k, pi_data);
            m_nb[k]   <= nbits(k);
            m_t[k]    <= 0;
            m_act[k]  <= 1'b1;
         end
      end
   end

   // Cycle-by-cycle compare of all instances against the model.
   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         logic etx, ebusy, edone;
         if (!rst_n || !m_act[k]) begin
            etx = 1'b1; ebusy = 1'b0; edone = 1'b0;
         end else begin
            etx   = m_bits[k][m_t[k] / M];
            ebusy = 1'b1;
            edone = (m_t[k] == m_nb[k] * M - 1);
         end
         checks++;
         if ({tx_w[k], busy_w[k], done_w[k]} !== {etx, ebusy, edone}) begin
            errors++;
            $display("FAIL model dut%0d t=%0t: tx/busy/done got %b%b%b expected %b%b%b",
                     k, $time, tx_w[k], busy_w[k], done_w[k], etx, ebusy, edone);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One-cycle request; returns #1 into the first cycle after the accept edge.
   task automatic send(input logic [7:0] d);
      @(posedge clk);
      #1 pi_flag = 1'b1;
      pi_data = d;
      @(posedge clk);
      #1 pi_flag = 1'b0;
   endtask

   // Sample tx mid-bit over one frame and count done pulses.
   task automatic capture(input int k, input int nb, output logic [15:0] w, output int dones);
      w = '0;
      dones = 0;
      for (int c = 0; c < nb * M; c++) begin
         @(negedge clk);
         if ((c % M) == 2) w[c / M] = tx_w[k];
         if (done_w[k]) dones++;
      end
   endtask

   task automatic wait_idle();
      bit found;
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge clk);
         if (busy_w == 4'h0) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL wait_idle: busy still %b after 300 cycles", busy_w);
      end
   endtask

   logic [15:0] w0, w1, w2, w3;
   int          d0, d1, d2, d3;
   bit          seen;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_tx", 32'(tx_w), 32'hF);
      chk("reset_busy", 32'(busy_w), 32'h0);
      chk("reset_done", 32'(done_w), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);

      // 8N1, 0x55
      send(8'h55);
      capture(0, 10, w0, d0);
      chk("frame_55", 32'(w0), 32'h2AA);
      chk("frame_55_done", 32'(d0), 32'd1);
      @(negedge clk);
      chk("frame_55_busy_drop", 32'(busy_w[0]), 32'd0);
      wait_idle();

      // Even and odd parity on 0x07
      send(8'h07);
      fork
         capture(1, 11, w1, d1);
         capture(2, 11, w2, d2);
      join
      chk("even_par_07", 32'(w1), 32'h60E);
      chk("odd_par_07", 32'(w2), 32'h40E);
      chk("even_par_done", 32'(d1), 32'd1);
      wait_idle();

      // 5 data bits, 2 stop bits
      send(8'h1F);
      capture(3, 8, w3, d3);
      chk("w5s2_1f", 32'(w3), 32'hFE);
      chk("w5s2_done", 32'(d3), 32'd1);
      wait_idle();

      // Request while busy is ignored
      send(8'h0F);
      fork
         capture(0, 10, w0, d0);
         begin
            repeat (20) @(posedge clk);
            #1 pi_flag = 1'b1;
            pi_data = 8'hAA;
            @(posedge clk);
            #1 pi_flag = 1'b0;
         end
      join
      chk("ignore_busy_0f", 32'(w0), 32'h21E);
      chk("ignore_busy_done", 32'(d0), 32'd1);
      wait_idle();
      chk("ignore_busy_idle", 32'(busy_w), 32'h0);

      // Back-to-back: flag raised during done (ignored) and held into the idle cycle
      send(8'h01);
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (done_w[0]) seen = 1'b1;
      end
      chk("b2b_done_seen", 32'(seen), 32'd1);
      pi_flag = 1'b1;
      pi_data = 8'h02;
      @(posedge clk);
      @(negedge clk);
      chk("b2b_gap_tx", 32'(tx_w[0]), 32'd1);
      chk("b2b_gap_busy", 32'(busy_w[0]), 32'd0);
      @(posedge clk);
      #1 pi_flag = 1'b0;
      @(negedge clk);
      chk("b2b_start_tx", 32'(tx_w[0]), 32'd0);
      chk("b2b_start_busy", 32'(busy_w[0]), 32'd1);
      wait_idle();

      // Reset in the middle of data bit 3 (a zero bit of 0xF0)
      send(8'hF0);
      repeat (22) @(negedge clk);
      chk("pre_reset_tx", 32'(tx_w[0]), 32'd0);
      #3 rst_n = 1'b0;
      #1;
      chk("async_reset_tx", 32'(tx_w), 32'hF);
      chk("async_reset_busy", 32'(busy_w), 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      send(8'h3C);
      capture(0, 10, w0, d0);
      chk("post_reset_3c", 32'(w0), 32'h278);
      chk("post_reset_done", 32'(d0), 32'd1);
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
